dfii_init_sequencer: RTL and testbench



---
 rtl/dfii_init_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dfii_init_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfii_init_sequencer.sv
// DDR3 bring-up sequencer: replays the DFII init writes as a
// Wishbone classic master, then hands the PHY to hardware control.
module dfii_init_sequencer #(
  parameter logic [29:0] BASE_ADR   = 30'h2400,
  parameter logic [31:0] MR0_VAL    = 32'h320,
  parameter logic [31:0] MR1_VAL    = 32'h6,
  parameter logic [31:0] MR2_VAL    = 32'h200,
  parameter logic [31:0] MR3_VAL    = 32'h0,
  parameter int unsigned T_RESET    = 50000,
  parameter int unsigned T_CKE      = 50000,
  parameter int unsigned T_MOD      = 200,
  parameter int unsigned T_ZQ       = 200,
  parameter int unsigned WB_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  err_step,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [29:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic        wb_ack,
  input  logic        wb_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_GAP, S_WAIT, S_DONE, S_ERROR
  } state_t;

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_CMD   = 3'd1;
  localparam logic [2:0] OFF_ISSUE = 3'd2;
  localparam logic [2:0] OFF_ADDR  = 3'd3;
  localparam logic [2:0] OFF_BADDR = 3'd4;

  localparam logic [4:0]  LAST_STEP = 5'd25;
  localparam logic [31:0] TO_LAST   = 32'(WB_TIMEOUT - 1);

  state_t      state;
  logic [4:0]  step;
  logic [4:0]  nxt_step;
  logic [2:0]  nxt_off;
  logic [31:0] nxt_dat;
  logic [31:0] cur_dly;
  logic [31:0] wcnt;
  logic [31:0] tcnt;
  logic        idle_like;
  logic        launch;

  assign idle_like = (state == S_IDLE) || (state == S_DONE) ||
                     (state == S_ERROR);

  assign launch = (idle_like && start) || (state == S_GAP) ||
                  (state == S_WAIT && wcnt == 32'd0);

  // Write table for the step about to be presented on the bus
  always_comb begin
    nxt_step = idle_like ? 5'd0 : step + 5'd1;
    nxt_off  = OFF_CTRL;
    nxt_dat  = 32'h0;
    case (nxt_step)
      5'd0:  begin nxt_off = OFF_CTRL;  nxt_dat = 32'h0E;  end
      5'd1:  begin nxt_off = OFF_ADDR;  nxt_dat = 32'h0;   end
      5'd2:  begin nxt_off = OFF_BADDR; nxt_dat = 32'h0;   end
      5'd3:  begin nxt_off = OFF_CTRL;  nxt_dat = 32'h0C;  end
      5'd4:  begin nxt_off = OFF_CTRL;  nxt_dat = 32'h0E;  end
      5'd5:  begin nxt_off = OFF_ADDR;  nxt_dat = MR2_VAL; end
      5'd6:  begin nxt_off = OFF_BADDR; nxt_dat = 32'h2;   end
      5'd9:  begin nxt_off = OFF_ADDR;  nxt_dat = MR3_VAL; end
      5'd10: begin nxt_off = OFF_BADDR; nxt_dat = 32'h3;   end
      5'd13: begin nxt_off = OFF_ADDR;  nxt_dat = MR1_VAL; end
      5'd14: begin nxt_off = OFF_BADDR; nxt_dat = 32'h1;   end
      5'd17: begin nxt_off = OFF_ADDR;  nxt_dat = MR0_VAL; end
      5'd18: begin nxt_off = OFF_BADDR; nxt_dat = 32'h0;   end
      5'd7, 5'd11, 5'd15, 5'd19: begin
        nxt_off = OFF_CMD;
        nxt_dat = 32'h0F;
      end
      5'd8, 5'd12, 5'd16, 5'd20, 5'd24: begin
        nxt_off = OFF_ISSUE;
        nxt_dat = 32'h01;
      end
      5'd21: begin nxt_off = OFF_ADDR;  nxt_dat = 32'h400; end
      5'd22: begin nxt_off = OFF_BADDR; nxt_dat = 32'h0;   end
      5'd23: begin nxt_off = OFF_CMD;   nxt_dat = 32'h03;  end
      default: begin nxt_off = OFF_CTRL; nxt_dat = 32'h01; end
    endcase
  end

  always_comb begin
    cur_dly = 32'd0;
    case (step)
      5'd3:    cur_dly = T_RESET;
      5'd4:    cur_dly = T_CKE;
      5'd20:   cur_dly = T_MOD;
      5'd24:   cur_dly = T_ZQ;
      default: cur_dly = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step     <= 5'd0;
      wcnt     <= 32'd0;
      tcnt     <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_step <= 5'd0;
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= 30'd0;
      wb_dat_w <= 32'd0;
      wb_sel   <= 4'h0;
    end else if (launch) begin
      state    <= S_WRITE;
      step     <= nxt_step;
      tcnt     <= 32'd0;
      busy     <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
      err_step <= 5'd0;
      wb_cyc   <= 1'b1;
      wb_stb   <= 1'b1;
      wb_we    <= 1'b1;
      wb_sel   <= 4'hF;
      wb_adr   <= BASE_ADR + {27'd0, nxt_off};
      wb_dat_w <= nxt_dat;
    end else begin
      unique case (state)
        S_WRITE: begin
          // err beats ack; a response in the last allowed cycle still counts
          if (wb_err || (!wb_ack && tcnt == TO_LAST)) begin
            state    <= S_ERROR;
            error    <= 1'b1;
            err_step <= step;
            busy     <= 1'b0;
            wb_cyc   <= 1'b0;
            wb_stb   <= 1'b0;
            wb_we    <= 1'b0;
            wb_sel   <= 4'h0;
          end else if (wb_ack) begin
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
            wb_sel <= 4'h0;
            if (step == LAST_STEP) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (cur_dly != 32'd0) begin
              state <= S_WAIT;
              wcnt  <= cur_dly;
            end else begin
              state <= S_GAP;
            end
          end else begin
            tcnt <= tcnt + 32'd1;
          end
        end
        S_WAIT:  wcnt <= wcnt - 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dfii_init_sequencer.sv
// Scoreboard bench for dfii_init_sequencer: directed runs against a
// configurable Wishbone slave, writes checked in order by a monitor.
`timescale 1ns/1ps
module tb_dfii_init_sequencer;

  localparam int unsigned TR = 13;
  localparam int unsigned TC = 11;
  localparam int unsigned TM = 7;
  localparam int unsigned TZ = 5;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [4:0]  err_step;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;

  always #5 clk = ~clk;

  dfii_init_sequencer #(
    .BASE_ADR(30'h2400), .MR0_VAL(32'h320), .MR1_VAL(32'h6),
    .MR2_VAL(32'h200), .MR3_VAL(32'h0),
    .T_RESET(TR), .T_CKE(TC), .T_MOD(TM), .T_ZQ(TZ),
    .WB_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .error(error), .err_step(err_step),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  typedef struct packed {
    logic [29:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t exp_q[$];

  int offs [26] = '{0, 3, 4, 0, 0,
                    3, 4, 1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4, 1, 2,
                    3, 4, 1, 2, 0};
  logic [31:0] dats [26] = '{
    32'h0E, 32'h0, 32'h0, 32'h0C, 32'h0E,
    32'h200, 32'h2, 32'h0F, 32'h1,
    32'h0, 32'h3, 32'h0F, 32'h1,
    32'h6, 32'h1, 32'h0F, 32'h1,
    32'h320, 32'h0, 32'h0F, 32'h1,
    32'h400, 32'h0, 32'h03, 32'h1,
    32'h01};

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int wr_idx = 0;
  int age = 0;
  int lat = 0;
  int err_idx = -1;
  bit both = 1'b0;
  bit mute = 1'b0;
  int rise_cnt = 0;
  int fall_cyc = 0;
  int last_ack_cyc = 0;
  int last_ack_step = 0;
  logic resp;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_idx <= 0;
    else if (start && !busy) wr_idx <= 0;
    else if (wb_cyc && (wb_ack || wb_err)) wr_idx <= wr_idx + 1;
  end

  always @(posedge clk)
    age <= (wb_cyc && !wb_ack && !wb_err) ? age + 1 : 0;

  assign resp   = wb_cyc && !mute && (age == lat);
  assign wb_err = resp && (wr_idx == err_idx);
  assign wb_ack = resp && ((wr_idx != err_idx) || both);

  function automatic int dly(input int s);
    case (s)
      3:       return TR;
      4:       return TC;
      20:      return TM;
      24:      return TZ;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic push_steps(input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.adr = 30'h2400 + 30'(offs[i]);
      e.dat = dats[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s = cyc_n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int bound, output int t);
    for (int i = 0; i < bound && !done && !error; i++) @(negedge clk);
    t = cyc_n;
    #1;
    if (!(done || error)) begin
      checks++;
      failures++;
      $display("FAIL end_wait actual=none required=done_or_error");
    end
  endtask

  task automatic wait_idx(input int n);
    for (int i = 0; i < 200 && wr_idx < n; i++) @(negedge clk);
    chk("reach_idx", 32'(wr_idx >= n), 1);
  endtask

  task automatic chk_zero(input string name);
    chk(name, 32'({busy, done, error, err_step, wb_cyc, wb_stb,
                   wb_we, wb_sel}), 0);
    chk({name, "_adr"}, 32'(wb_adr), 0);
    chk({name, "_dat"}, wb_dat_w, 0);
  endtask

  // Monitor: pops expected writes on each bus completion
  initial begin
    logic        prev_cyc;
    logic [29:0] prev_adr;
    logic [31:0] prev_dat;
    wr_t         e;
    prev_cyc = 1'b0;
    prev_adr = '0;
    prev_dat = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc) begin
        chk("ctl", 32'({wb_stb, wb_we, wb_sel}), 32'h3F);
        if (prev_cyc) begin
          chk("adr_stable", 32'(wb_adr), 32'(prev_adr));
          chk("dat_stable", wb_dat_w, prev_dat);
        end else begin
          rise_cnt++;
          if (wr_idx != 0)
            chk("gap", 32'(cyc_n - last_ack_cyc),
                32'(2 + dly(last_ack_step)));
        end
        if (wb_ack || wb_err) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_write actual=%0h required=none",
                     wb_adr);
          end else begin
            e = exp_q.pop_front();
            chk("wr_adr", 32'(wb_adr), 32'(e.adr));
            chk("wr_dat", wb_dat_w, e.dat);
          end
          if (wb_ack) begin
            last_ack_cyc = cyc_n;
            last_ack_step = wr_idx;
          end
        end
      end else if (prev_cyc) begin
        fall_cyc = cyc_n;
      end
      prev_cyc = wb_cyc;
      prev_adr = wb_adr;
      prev_dat = wb_dat_w;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, t, r;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;

    // nominal, zero-wait slave
    lat = 0;
    push_steps(26);
    do_start(s);
    chk("start_busy", 32'(busy), 1);
    chk("start_cyc", 32'(wb_cyc), 1);
    wait_end(400, t);
    chk("nom_done", 32'({done, error, busy}), 32'h4);
    chk("nom_cycles", 32'(t - s), 88);
    chk("nom_q", 32'(exp_q.size()), 0);

    // slow slave answering in the last cycle before timeout
    lat = 7;
    push_steps(26);
    do_start(s);
    wait_end(600, t);
    chk("slow_done", 32'({done, error}), 32'h2);
    chk("slow_cycles", 32'(t - s), 270);
    chk("slow_q", 32'(exp_q.size()), 0);

    // bus error on step 13, then restart
    lat = 0;
    err_idx = 13;
    push_steps(14);
    do_start(s);
    wait_end(200, t);
    chk("err_flags", 32'({done, error, busy, wb_cyc}), 32'h4);
    chk("err_step", 32'(err_step), 13);
    chk("err_cycle", 32'(t - s), 52);
    r = rise_cnt;
    repeat (40) @(negedge clk);
    chk("err_quiet", 32'(rise_cnt), 32'(r));
    chk("err_q", 32'(exp_q.size()), 0);
    err_idx = -1;
    push_steps(26);
    do_start(s);
    chk("restart_clr", 32'({error, err_step}), 0);
    wait_end(400, t);
    chk("restart_done", 32'({done, error}), 32'h2);
    chk("restart_cycles", 32'(t - s), 88);

    // silent slave: timeout on step 0
    mute = 1'b1;
    do_start(s);
    wait_end(40, t);
    chk("to_cycle", 32'(t - s), 9);
    chk("to_fall", 32'(fall_cyc - s), 9);
    chk("to_flags", 32'({error, busy, wb_cyc, done}), 32'h8);
    chk("to_step", 32'(err_step), 0);
    mute = 1'b0;

    // ack and err together on step 6
    both = 1'b1;
    err_idx = 6;
    push_steps(7);
    do_start(s);
    wait_end(200, t);
    chk("both_flags", 32'({error, done}), 32'h2);
    chk("both_step", 32'(err_step), 6);
    chk("both_cycle", 32'(t - s), 38);
    chk("both_q", 32'(exp_q.size()), 0);
    both = 1'b0;
    err_idx = -1;

    // reset during CKE wait, restart, stray start while busy
    push_steps(26);
    do_start(s);
    wait_idx(5);
    repeat (3) @(negedge clk);
    chk("cke_wait", 32'({busy, wb_cyc}), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_steps(26);
    do_start(s);
    wait_idx(3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(400, t);
    chk("rs_done", 32'({done, error}), 32'h2);
    chk("rs_cycles", 32'(t - s), 88);
    chk("rs_q", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
